sci_frame_rx: RTL and testbench
===============================

# sci_frame_rx

Serial receive front end for the NN core. Deserialises 8N1 UART traffic on `rxd` and assembles header/payload/checksum frames into the `I_NUM`-bit input vector `a_in`. On each valid frame it issues a one-cycle `nn_start` to the core. It sits upstream of the core's input path; the transmit side is unaffected.

## Interface
- `CLK_DIV`, 434: clocks per UART bit, ≥ 4. 434 gives 115200 baud at 50 MHz.
- `I_NUM`, 16: width of `a_in`, 1..64.
- `HDR`, 8'hA5: frame header byte.
- `TIMEOUT_BITS`, 32: inter-byte timeout, counted in bit-times.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `rxd`  in  1: asynchronous UART line, idle high.
- `core_busy`  in  1: high while the core is computing (between `nn_start` and `nn_finish`).
- `a_in`  out  `I_NUM`: registered input vector; holds the last accepted frame.
- `nn_start`  out  1: one-cycle pulse when `a_in` is updated.
- `frame_err`  out  1: one-cycle pulse on checksum mismatch or timeout.
- `rx_err`  out  1: one-cycle pulse on a byte with a bad stop bit.
- `busy_drop`  out  1: one-cycle pulse when a good frame is discarded because `core_busy` = 1.

## Operation
- **Reset values.** All outputs reset to 0 and `a_in` resets to 0. Both FSMs reset to their idle state, all counters reset to 0, and the synchroniser flops reset to 1.
- **rxd synchroniser.** `rxd` passes through a 2-flop synchroniser; all logic uses the synchronised copy `rxs`.
- **Bit receiver FSM, states `IDLE`, `START`, `DATA`, `STOP`.**
  - `IDLE`: a 1→0 transition of `rxs` moves to `START` and clears the divider.
  - `START`: at divider count `CLK_DIV/2-1`, if `rxs` = 1 (glitch) return to `IDLE` with no flag; otherwise clear the divider and go to `DATA`.
  - `DATA`: sample `rxs` at each divider wrap (`CLK_DIV-1`), LSB first, into an 8-bit shift register. After 8 samples go to `STOP`.
  - `STOP`: at the wrap, `rxs` = 1 produces an internal `byte_valid` for 1 cycle; `rxs` = 0 pulses `rx_err` and the byte is discarded. Both cases return to `IDLE`.
- **Frame FSM, states `HUNT`, `PAYLOAD`, `CHECK`.**
  - `HUNT`: a byte equal to `HDR` clears the XOR accumulator and the byte index, then goes to `PAYLOAD`. Any other byte is ignored.
  - `PAYLOAD`: `NB = ceil(I_NUM/8)` bytes, least-significant byte first, written into a staging register and XORed into the accumulator. Bits at or above `I_NUM` in the last byte are ignored, but they are still included in the XOR. After `NB` bytes go to `CHECK`.
  - `CHECK`: the next byte is compared with the accumulator.
    - Equal and `core_busy` = 0: load `a_in` from staging and pulse `nn_start`.
    - Equal and `core_busy` = 1: pulse `busy_drop`; `a_in` is unchanged.
    - Not equal: pulse `frame_err`.
    - In every case return to `HUNT`.
- **Timeout.** In `PAYLOAD` or `CHECK`, the timeout counter clears on every `byte_valid`. If `TIMEOUT_BITS*CLK_DIV` clocks pass without a byte, pulse `frame_err` and return to `HUNT`.
- **Error bytes.** An `rx_err` byte does not advance the frame FSM; only the timeout recovers from it.
- **`HDR` inside a frame.** An `HDR` value arriving in `PAYLOAD`/`CHECK` is treated as data; there is no resync.
- **Reset mid-frame or mid-byte.** The current frame and any partial byte are abandoned and no pulse is produced.

## Timing
- **Byte latency.** `byte_valid` occurs `2 + CLK_DIV/2 + 9*CLK_DIV` clocks after the 1→0 edge on `rxd` (2 synchroniser cycles).
- **Frame decision.** `a_in` updates and `nn_start` rises on the clock edge after the `byte_valid` of the checksum byte (1 cycle later). `frame_err` and `busy_drop` follow the same 1-cycle latency.
- **Pulse width.** All pulse outputs are exactly 1 cycle wide. At most one of `nn_start`/`frame_err`/`busy_drop` is asserted in any cycle.
- **`core_busy` sampling.** `core_busy` is sampled in the same cycle as the checksum `byte_valid`.
- **Back-to-back bytes.** A new start edge is accepted from the cycle after the `STOP` decision, so back-to-back bytes at full line rate are received without loss.

## Test plan
All scenarios use `CLK_DIV`=8, `I_NUM`=16.
1. Send A5 34 12 26 → `a_in`=16'h1234, one `nn_start` pulse exactly 1 cycle after the 4th `byte_valid`, no error pulses.
2. Send A5 34 12 27 → one `frame_err` pulse, `a_in` stays 16'h1234, no `nn_start`.
3. Hold `core_busy`=1 and send A5 FF 00 FF → one `busy_drop` pulse, `a_in` unchanged. Release `core_busy` and resend → `a_in`=16'h00FF plus one `nn_start`.
4. Send A5 34, then idle for 32×8 clocks → one `frame_err` at timeout. Then send A5 01 02 03 → `a_in`=16'h0201.
5. Drive a 3-clock low glitch on `rxd` → no `byte_valid`, no pulses. Send a byte whose stop bit is 0 → one `rx_err`, frame FSM stays in its current state.
6. Send A5 34 1, assert `rst_n`=0 for 1 cycle mid-byte, then send A5 AA 55 FF → `a_in`=16'h55AA plus one `nn_start`, all outputs 0 during reset.

Source files
------------

// File: rtl/sci_frame_rx.sv
// 8N1 UART receiver plus header/payload/XOR-checksum framer that loads a_in and pulses nn_start.
// Decision 1 clk after the checksum byte's stop sample; no backpressure: frames arriving while core_busy are dropped (busy_drop).
module sci_frame_rx #(
   parameter int         CLK_DIV      = 434,
   parameter int         I_NUM        = 16,
   parameter logic [7:0] HDR          = 8'hA5,
   parameter int         TIMEOUT_BITS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rxd,
   input  logic             core_busy,
   output logic [I_NUM-1:0] a_in,
   output logic             nn_start,
   output logic             frame_err,
   output logic             rx_err,
   output logic             busy_drop
);

   localparam int NB = (I_NUM + 7) / 8;
   localparam int DW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NB + 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
   localparam logic [DW-1:0] DIV_WRAP = DW'(CLK_DIV - 1);
   localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_BITS * CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] F_HUNT    = 2'd0;
   localparam logic [1:0] F_PAYLOAD = 2'd1;
   localparam logic [1:0] F_CHECK   = 2'd2;

   logic          sync1, rxs, rxs_d;
   logic [1:0]    rx_st;
   logic [DW-1:0] div;
   logic [2:0]    bit_cnt;
   logic [7:0]    sr;
   logic          byte_valid;

   logic [1:0]      fr_st;
   logic [7:0]      acc;
   logic [IW-1:0]   idx;
   logic [NB*8-1:0] stage;
   logic [31:0]     to_cnt;
   logic            timeout;

   // Stop bit sampled at mid-bit; the byte is handed over combinationally in that same cycle.
   assign byte_valid = (rx_st == S_STOP) && (div == DIV_WRAP) && rxs;
   assign timeout    = (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
         rx_st   <= S_IDLE;
         div     <= '0;
         bit_cnt <= '0;
         sr      <= '0;
         rx_err  <= 1'b0;
      end else begin
         sync1  <= rxd;
         rxs    <= sync1;
         rxs_d  <= rxs;
         rx_err <= 1'b0;
         case (rx_st)
            S_IDLE: begin
               if (rxs_d && !rxs) begin
                  rx_st <= S_START;
                  div   <= '0;
               end
            end
            S_START: begin
               if (div == DIV_HALF) begin
                  div <= '0;
                  if (rxs) begin
                     rx_st <= S_IDLE;
                  end else begin
                     rx_st   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_DATA: begin
               if (div == DIV_WRAP) begin
                  div     <= '0;
                  sr      <= {rxs, sr[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) rx_st <= S_STOP;
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_STOP: begin
               if (div == DIV_WRAP) begin
                  div    <= '0;
                  rx_st  <= S_IDLE;
                  rx_err <= !rxs;
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: rx_st <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fr_st     <= F_HUNT;
         acc       <= '0;
         idx       <= '0;
         stage     <= '0;
         to_cnt    <= '0;
         a_in      <= '0;
         nn_start  <= 1'b0;
         frame_err <= 1'b0;
         busy_drop <= 1'b0;
      end else begin
         nn_start  <= 1'b0;
         frame_err <= 1'b0;
         busy_drop <= 1'b0;
         if (fr_st == F_HUNT || byte_valid) to_cnt <= '0;
         else                               to_cnt <= to_cnt + 1'b1;
         case (fr_st)
            F_HUNT: begin
               if (byte_valid && sr == HDR) begin
                  acc   <= '0;
                  idx   <= '0;
                  fr_st <= F_PAYLOAD;
               end
            end
            F_PAYLOAD: begin
               // Padding bits of the last byte still feed the checksum.
               if (byte_valid) begin
                  stage[idx*8 +: 8] <= sr;
                  acc               <= acc ^ sr;
                  idx               <= idx + 1'b1;
                  if (idx == IDX_LAST) fr_st <= F_CHECK;
               end else if (timeout) begin
                  frame_err <= 1'b1;
                  fr_st     <= F_HUNT;
               end
            end
            F_CHECK: begin
               if (byte_valid) begin
                  fr_st <= F_HUNT;
                  if (sr != acc) begin
                     frame_err <= 1'b1;
                  end else if (core_busy) begin
                     busy_drop <= 1'b1;
                  end else begin
                     a_in     <= stage[I_NUM-1:0];
                     nn_start <= 1'b1;
                  end
               end else if (timeout) begin
                  frame_err <= 1'b1;
                  fr_st     <= F_HUNT;
               end
            end
            default: fr_st <= F_HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_sci_frame_rx.sv
// Scoreboard bench for sci_frame_rx: each expected pulse (kind, cycle, a_in) is queued as the byte is driven.
module tb_sci_frame_rx;

   localparam int CLK_DIV = 8;
   localparam int I_NUM   = 16;
   localparam int TO_BITS = 32;
   localparam int LAT     = 3 + CLK_DIV / 2 + 9 * CLK_DIV;
   localparam int TO_CLKS = TO_BITS * CLK_DIV;

   localparam int K_START = 1;
   localparam int K_FERR  = 2;
   localparam int K_BUSY  = 3;
   localparam int K_RXERR = 4;

   logic             clk;
   logic             rst_n;
   logic             rxd;
   logic             core_busy;
   logic [I_NUM-1:0] a_in;
   logic             nn_start;
   logic             frame_err;
   logic             rx_err;
   logic             busy_drop;

   sci_frame_rx #(
      .CLK_DIV     (CLK_DIV),
      .I_NUM       (I_NUM),
      .HDR         (8'hA5),
      .TIMEOUT_BITS(TO_BITS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rxd      (rxd),
      .core_busy(core_busy),
      .a_in     (a_in),
      .nn_start (nn_start),
      .frame_err(frame_err),
      .rx_err   (rx_err),
      .busy_drop(busy_drop)
   );

   typedef struct {
      int          kind;
      logic [15:0] a;
      int          at;
   } ev_t;

   ev_t         sb[$];
   int          cyc;
   int          n_chk;
   int          n_pass;
   logic [15:0] a_model;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   int  mon_kind;
   int  mon_sum;
   ev_t mon_e;
   always @(negedge clk) begin
      if (rst_n && (nn_start || frame_err || busy_drop || rx_err)) begin
         mon_sum = int'(nn_start) + int'(frame_err) + int'(busy_drop);
         check_eq("decision_onehot", 32'(mon_sum <= 1), 32'd1);
         mon_kind = nn_start ? K_START : frame_err ? K_FERR : busy_drop ? K_BUSY : K_RXERR;
         if (sb.size() == 0) begin
            check_eq("unexpected_pulse", 32'(mon_kind), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
            check_eq("pulse_cycle", 32'(cyc), 32'(mon_e.at));
            check_eq("a_in", 32'(a_in), 32'(mon_e.a));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the stop bit, so calls chain at full line rate.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int kind,
                            input logic [15:0] a_exp, output int t0);
      ev_t e;
      t0  = cyc;
      rxd = 1'b0;
      if (kind != 0) begin
         e.kind = kind;
         e.a    = a_exp;
         e.at   = t0 + LAT;
         sb.push_back(e);
      end
      idle(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(CLK_DIV);
      end
      rxd = stop_ok;
      idle(CLK_DIV);
      rxd = 1'b1;
      if (!stop_ok) idle(CLK_DIV);
   endtask

   task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] ck,
                             input int kind);
      int t;
      send_byte(8'hA5, 1'b1, 0, a_model, t);
      send_byte(b1, 1'b1, 0, a_model, t);
      send_byte(b2, 1'b1, 0, a_model, t);
      if (kind == K_START) a_model = {b2, b1};
      send_byte(ck, 1'b1, kind, a_model, t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      n_chk     = 0;
      n_pass    = 0;
      a_model   = 16'h0000;
      rxd       = 1'b1;
      core_busy = 1'b0;
      rst_n     = 1'b0;
      idle(4);
      check_eq("rst_a_in", 32'(a_in), 32'd0);
      check_eq("rst_nn_start", 32'(nn_start), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_rx_err", 32'(rx_err), 32'd0);
      check_eq("rst_busy_drop", 32'(busy_drop), 32'd0);
      rst_n = 1'b1;
      idle(4);

      // good frame
      send_frame(8'h34, 8'h12, 8'h26, K_START);
      idle(20);
      // bad checksum
      send_frame(8'h34, 8'h12, 8'h27, K_FERR);
      idle(20);
      // dropped while core busy, then accepted
      core_busy = 1'b1;
      send_frame(8'hFF, 8'h00, 8'hFF, K_BUSY);
      idle(4);
      core_busy = 1'b0;
      send_frame(8'hFF, 8'h00, 8'hFF, K_START);
      idle(20);
      check_eq("a_in_00ff", 32'(a_in), 32'h00FF);

      // inter-byte timeout, then recovery
      send_byte(8'hA5, 1'b1, 0, a_model, t);
      send_byte(8'h34, 1'b1, 0, a_model, t);
      begin
         ev_t e;
         e.kind = K_FERR;
         e.a    = a_model;
         e.at   = t + LAT + TO_CLKS;
         sb.push_back(e);
      end
      idle(TO_CLKS + 20);
      send_frame(8'h01, 8'h02, 8'h03, K_START);
      idle(20);

      // start glitch is rejected silently
      rxd = 1'b0;
      idle(3);
      rxd = 1'b1;
      idle(3 * CLK_DIV);

      // bad stop bit mid-frame does not advance the payload index
      send_byte(8'hA5, 1'b1, 0, a_model, t);
      send_byte(8'h34, 1'b1, 0, a_model, t);
      send_byte(8'h77, 1'b0, K_RXERR, a_model, t);
      send_byte(8'h12, 1'b1, 0, a_model, t);
      send_byte(8'h26, 1'b1, K_START, 16'h1234, t);
      a_model = 16'h1234;
      idle(20);

      // reset mid-frame and mid-byte
      send_byte(8'hA5, 1'b1, 0, a_model, t);
      send_byte(8'h34, 1'b1, 0, a_model, t);
      rxd = 1'b0;
      idle(CLK_DIV);
      rxd = 1'b1;
      idle(3);
      rst_n = 1'b0;
      idle(1);
      check_eq("midrst_a_in", 32'(a_in), 32'd0);
      check_eq("midrst_pulses", 32'({nn_start, frame_err, rx_err, busy_drop}), 32'd0);
      rst_n   = 1'b1;
      a_model = 16'h0000;
      idle(12 * CLK_DIV);
      send_frame(8'hAA, 8'h55, 8'hFF, K_START);

      for (int i = 0; i < 400; i++) begin
         if (sb.size() == 0) break;
         idle(1);
      end
      idle(20);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      check_eq("a_in_final", 32'(a_in), 32'h55AA);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
